// File: rtl/ro_pkg.sv
// Shared types and stream-format constants for the readout channel arbiter.
// The header word carries a magic nibble, the granted channel and the burst length.
package ro_pkg;

  localparam int STREAM_W      = 32;
  localparam int LEN_W         = 16;
  localparam int HDR_MAGIC_LSB = 28;
  localparam int HDR_CH_LSB    = 24;
  localparam int HDR_LEN_LSB   = 0;

  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } ro_state_t;

  function automatic logic [STREAM_W-1:0] make_header(input logic [3:0]       ch,
                                                      input logic [LEN_W-1:0] len);
    logic [STREAM_W-1:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 4]     = HDR_MAGIC;
    h[HDR_CH_LSB +: 4]        = ch;
    h[HDR_LEN_LSB +: LEN_W]   = len;
    return h;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: the search starts one past last_grant
// and wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any_req
);

  int            idx;
  logic [IW-1:0] sel;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N) idx = idx - N;
      sel = IW'(idx);
      if (!any_req && req[sel]) begin
        any_req = 1'b1;
        grant   = sel;
      end
    end
  end

endmodule

// File: rtl/ro_channel_arbiter.sv
// Round-robin readout scheduler: grants one non-empty channel FIFO at a time and
// streams a header word followed by a bounded burst of that channel's samples.
module ro_channel_arbiter
  import ro_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int DW       = 16,
  parameter int CNTW     = 10,
  parameter int MAXBURST = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NCH-1:0]      ch_empty,
  input  logic [NCH*CNTW-1:0] ch_count,
  input  logic [NCH*DW-1:0]   ch_data,
  output logic [NCH-1:0]      ch_rd_en,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eof,
  output logic                busy,
  output logic [3:0]          grant_ch,
  output logic [1:0]          dbg_state
);

  // Stream handshake: a word moves when out_valid && out_ready at a rising edge.
  // While out_ready is low the presented word and its flags are held and nothing pops.

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [IW-1:0]    LAST_RST = IW'(NCH - 1);

  ro_state_t         state, state_nxt;
  logic [IW-1:0]     g, g_nxt;
  logic [IW-1:0]     last_grant, last_nxt;
  logic [LEN_W-1:0]  len, len_nxt;
  logic [LEN_W-1:0]  rem, rem_nxt;

  logic [NCH-1:0]    elig;
  logic [IW-1:0]     win;
  logic              any_req;
  logic [31:0]       win_cnt;
  logic [LEN_W-1:0]  burst_len;
  logic              g_empty;
  logic [DW-1:0]     g_data;
  logic              xfer;

  // A channel whose count still reads zero is skipped even if its empty flag dropped.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = !ch_empty[i] && (ch_count[i*CNTW +: CNTW] != '0);
    end
  end

  rr_arbiter #(.N(NCH)) u_rr_arbiter (
    .req        (elig),
    .last_grant (last_grant),
    .grant      (win),
    .any_req    (any_req)
  );

  always_comb begin
    win_cnt   = 32'(ch_count[int'(win)*CNTW +: CNTW]);
    burst_len = (win_cnt > 32'(MAXBURST)) ? LEN_W'(MAXBURST) : LEN_W'(win_cnt);
  end

  assign g_empty = ch_empty[g];
  assign g_data  = ch_data[int'(g)*DW +: DW];
  assign xfer    = (state == ST_DATA) && !g_empty && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      g          <= '0;
      last_grant <= LAST_RST;
      len        <= '0;
      rem        <= '0;
    end else begin
      state      <= state_nxt;
      g          <= g_nxt;
      last_grant <= last_nxt;
      len        <= len_nxt;
      rem        <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    last_nxt  = last_grant;
    len_nxt   = len;
    rem_nxt   = rem;
    unique case (state)
      ST_IDLE: begin
        if (enable && any_req) begin
          g_nxt     = win;
          len_nxt   = burst_len;
          rem_nxt   = burst_len;
          state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (out_ready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (xfer) begin
          rem_nxt = rem - LEN_ONE;
          if (rem == LEN_ONE) begin
            last_nxt  = g;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    out_data  = '0;
    ch_rd_en  = '0;
    unique case (state)
      ST_HDR: begin
        out_valid = 1'b1;
        out_sof   = 1'b1;
        out_data  = make_header(4'(g), len);
      end
      ST_DATA: begin
        out_valid = !g_empty;
        out_eof   = (rem == LEN_ONE);
        out_data  = STREAM_W'(g_data);
        if (xfer) ch_rd_en[g] = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign grant_ch  = 4'(g);
  assign dbg_state = state;

endmodule

// File: tb/tb_ro_channel_arbiter.sv
// Scoreboard bench: FIFO contents live in bench queues; a burst-level model turns
// them into the expected word stream, and a monitor checks every accepted word.
module tb_ro_channel_arbiter;

  localparam int NCH      = 4;
  localparam int DW       = 16;
  localparam int CNTW     = 10;
  localparam int MAXBURST = 64;
  localparam int EW       = 39;  // {ch[3:0], is_data, sof, eof, data[31:0]}

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic [NCH-1:0]      ch_empty;
  logic [NCH*CNTW-1:0] ch_count;
  logic [NCH*DW-1:0]   ch_data;
  logic [NCH-1:0]      ch_rd_en;
  logic [31:0]         out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_sof;
  logic                out_eof;
  logic                busy;
  logic [3:0]          grant_ch;
  logic [1:0]          dbg_state;

  logic [DW-1:0] fifo_q [NCH][$];
  logic [NCH-1:0] lag_zero;
  logic [EW-1:0]  exp_q [$];
  int             checks;
  int             failures;
  int             model_last;
  logic           mon_en;
  logic           rnd_ready;

  ro_channel_arbiter #(
    .NCH(NCH), .DW(DW), .CNTW(CNTW), .MAXBURST(MAXBURST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ch_empty  (ch_empty),
    .ch_count  (ch_count),
    .ch_data   (ch_data),
    .ch_rd_en  (ch_rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy),
    .grant_ch  (grant_ch),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NCH; i++) begin
      ch_empty[i] = (fifo_q[i].size() == 0);
      ch_count[i*CNTW +: CNTW] = lag_zero[i] ? '0 : CNTW'(fifo_q[i].size());
      ch_data[i*DW +: DW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
  endtask

  task automatic load(input int ch, input int n);
    for (int k = 0; k < n; k++) fifo_q[ch].push_back(DW'($urandom_range(0, 16'hFFFF)));
    refresh();
  endtask

  // Burst-level reference: round-robin over eligible channels from the bench FIFOs.
  task automatic drain_model(input int max_bursts);
    int   pos [NCH];
    int   c;
    int   len;
    bit   found;
    logic [31:0] hdr;
    for (int i = 0; i < NCH; i++) pos[i] = 0;
    for (int b = 0; b < max_bursts; b++) begin
      found = 0;
      c = 0;
      for (int k = 1; k <= NCH && !found; k++) begin
        c = (model_last + k) % NCH;
        if (!lag_zero[c] && (fifo_q[c].size() - pos[c]) > 0) found = 1;
      end
      if (!found) break;
      len = fifo_q[c].size() - pos[c];
      if (len > MAXBURST) len = MAXBURST;
      hdr = 32'hA000_0000 | (32'(c) << 24) | 32'(len);
      exp_q.push_back({4'(c), 1'b0, 1'b1, 1'b0, hdr});
      for (int k = 0; k < len; k++)
        exp_q.push_back({4'(c), 1'b1, 1'b0, (k == len - 1), 32'(fifo_q[c][pos[c] + k])});
      pos[c] += len;
      model_last = c;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_sof(input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (out_valid && out_sof) seen = 1;
    end
    chk("sof_seen", 64'(seen), 64'd1);
  endtask

  // FIFO pops follow the DUT strobes; a strobe cut short by reset does not pop.
  logic [NCH-1:0] pend;
  initial begin
    pend = '0;
    forever begin
      @(negedge clk);
      pend = ch_rd_en;
      @(posedge clk);
      if (rst_n) begin
        for (int i = 0; i < NCH; i++)
          if (pend[i] && fifo_q[i].size() != 0) void'(fifo_q[i].pop_front());
      end
      #1 refresh();
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic          stall_prev;
  logic [33:0]   prev_word;
  logic          gap_next;
  logic [EW-1:0] e;

  initial begin
    stall_prev = 0;
    gap_next   = 0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        stall_prev = 0;
        gap_next   = 0;
        continue;
      end
      if (gap_next) begin
        chk("gap_valid", 64'(out_valid), 64'd0);
        chk("gap_busy", 64'(busy), 64'd0);
        gap_next = 0;
      end
      if (stall_prev)
        chk("stall_stable", 64'({out_valid, out_sof, out_eof, out_data}), 64'({1'b1, prev_word}));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("word", 64'({out_sof, out_eof, out_data}), 64'(e[33:0]));
          chk("rd_en", 64'(ch_rd_en), e[34] ? 64'(1) << e[38:35] : 64'd0);
          chk("grant_ch", 64'(grant_ch), 64'(e[38:35]));
          chk("busy", 64'(busy), 64'd1);
          if (e[32]) gap_next = 1;
        end
      end else begin
        chk("rd_en_idle", 64'(ch_rd_en), 64'd0);
      end
      stall_prev = out_valid && !out_ready;
      prev_word  = {out_sof, out_eof, out_data};
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk_all_zero(input string name);
    chk(name, 64'({out_valid, out_sof, out_eof, ch_rd_en, busy, out_data, grant_ch}), 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; enable = 1'b0; lag_zero = '0; mon_en = 1'b1; rnd_ready = 1'b0;
    model_last = NCH - 1;
    ch_empty = '1; ch_count = '0; ch_data = '0;
    refresh();
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    // ch0 x3 and ch2 x5; header one cycle after enable
    load(0, 3); load(2, 5);
    drain_model(100);
    enable = 1'b1;
    @(negedge clk);
    chk("arb_latency", 64'({out_valid, out_sof}), 64'b11);
    chk("first_hdr", 64'(out_data), 64'hA000_0003);
    wait_drain(200);

    // ch1 x100 splits into 64 + 36
    load(1, 100);
    drain_model(100);
    wait_drain(400);

    // all channels loaded, random backpressure
    rnd_ready = 1'b1;
    for (int i = 0; i < NCH; i++) load(i, $urandom_range(1, 150));
    drain_model(100);
    wait_drain(4000);

    // ch3 len 8 under random backpressure
    load(3, 8);
    drain_model(100);
    wait_drain(400);

    // enable dropped mid-burst of len 10
    rnd_ready = 1'b0;
    enable = 1'b0;
    load(1, 10); load(2, 5);
    drain_model(1);
    enable = 1'b1;
    wait_sof(20);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_drain(100);
    repeat (20) @(negedge clk);
    chk("no_hdr_while_disabled", 64'({busy, out_valid}), 64'd0);
    drain_model(100);
    enable = 1'b1;
    wait_drain(200);

    // ch0 not empty but count lagging at zero
    lag_zero[0] = 1'b1;
    load(0, 2); load(1, 3);
    drain_model(100);
    wait_drain(200);
    repeat (10) @(negedge clk);
    chk("lag_not_granted", 64'(busy), 64'd0);
    lag_zero[0] = 1'b0;
    refresh();
    drain_model(100);
    wait_drain(200);

    // reset mid-burst on ch2, then ch0 must win first
    mon_en = 1'b0;
    load(2, 20);
    wait_sof(20);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_reset_outputs");
    @(negedge clk);
    chk_all_zero("reset_hold_outputs");
    load(0, 3);
    rst_n = 1'b1;
    mon_en = 1'b1;
    model_last = NCH - 1;
    drain_model(100);
    @(negedge clk);
    chk("post_reset_first", 64'({out_sof, grant_ch}), 64'({1'b1, 4'd0}));
    wait_drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
